// File: rtl/source_operand_if.sv
// Operand bus between the control/register-file side and the operand stage.
// The master drives the register operand, immediate field and select code;
// the slave returns the registered second source operand.
interface source_operand_if;
   logic [31:0] R;    // register-file operand (rs2 value)
   logic [21:0] Imm;  // instruction word bits [21:0]
   logic [3:0]  IS;   // operand-select code
   logic [31:0] N;    // registered operand to the ALU

   modport master (output R, output Imm, output IS, input N);
   modport slave  (input R, input Imm, input IS, output N);
endinterface

// File: rtl/source_operand.sv
// Second source operand selector for the ALU.
// Forms the operand from the register value or one of the immediate formats
// (SETHI, disp22, simm13, shift counts) and registers it with one cycle of
// latency. There is no handshake; a new operand is accepted every cycle.
module source_operand (
   input  logic           clk,
   input  logic           reset,
   source_operand_if.slave bus
);

   logic [31:0] n_d;
   logic [31:0] n_q;

   // Sign-extend the 13-bit immediate; only Imm[12] is replicated so the
   // upper immediate bits never leak into the operand.
   function automatic logic [31:0] sext13(input logic [12:0] f);
      sext13 = {{19{f[12]}}, f};
   endfunction

   // Sign-extend the full 22-bit displacement from Imm[21].
   function automatic logic [31:0] sext22(input logic [21:0] f);
      sext22 = {{10{f[21]}}, f};
   endfunction

   // Operand select: every IS code maps to a defined value. IS[1:0] is a
   // don't-care for 00xx/01xx and IS[1] is a don't-care for 11xx.
   always_comb begin
      n_d = 32'h0000_0000;
      case (bus.IS[3:2])
         2'b00: n_d = {bus.Imm, 10'b0};
         2'b01: n_d = sext22(bus.Imm);
         2'b10: begin
            case (bus.IS[1:0])
               2'b00:   n_d = bus.R;
               2'b01:   n_d = sext13(bus.Imm[12:0]);
               2'b10:   n_d = {27'b0, bus.R[4:0]};
               default: n_d = {27'b0, bus.Imm[4:0]};
            endcase
         end
         default: n_d = bus.IS[0] ? sext13(bus.Imm[12:0]) : bus.R;
      endcase
   end

   // Operand register; reset clears it and wins over the update.
   always_ff @(posedge clk) begin
      if (reset) begin
         n_q <= 32'h0000_0000;
      end else begin
         n_q <= n_d;
      end
   end

   assign bus.N = n_q;

endmodule

// File: tb/tb_source_operand.sv
// Scoreboard bench for source_operand: the driver pushes the hand-computed
// operand expected after each edge; the monitor pops and compares one entry
// per rising edge.
module tb_source_operand;

   logic clk;
   logic reset;

   source_operand_if bus ();

   source_operand dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 1'b0;

   localparam logic [21:0] IMM_A = 22'b1000110001000100010011; // 0x231113
   localparam logic [21:0] IMM_B = 22'b1000110000000100010011; // 0x230113

   // Drive one cycle of inputs at the falling edge and record what N must
   // hold after the following rising edge.
   task automatic drive(input logic rst, input logic [31:0] r,
                        input logic [21:0] imm, input logic [3:0] is,
                        input logic [31:0] exp, input string name);
      exp_t e;
      @(negedge clk);
      reset   = rst;
      bus.R   = r;
      bus.Imm = imm;
      bus.IS  = is;
      e.exp   = exp;
      e.name  = name;
      exp_q.push_back(e);
   endtask

   // Monitor: one comparison per rising edge while entries are pending.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.N !== e.exp) begin
               failures++;
               $display("FAIL %s: N=%h expected=%h", e.name, bus.N, e.exp);
            end
         end
      end
   end

   initial begin
      reset   = 1'b1;
      bus.R   = 32'h0;
      bus.Imm = 22'h0;
      bus.IS  = 4'h0;

      // Reset held two cycles with inputs that would select all ones.
      drive(1'b1, 32'hFFFF_FFFF, IMM_A, 4'b1000, 32'h0000_0000, "reset0");
      drive(1'b1, 32'hFFFF_FFFF, IMM_A, 4'b1000, 32'h0000_0000, "reset1");
      drive(1'b0, 32'hFFFF_FFFF, IMM_A, 4'b1000, 32'hFFFF_FFFF, "release");

      // Full IS sweep with R = E0000003, Imm = 0x231113.
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b0000, 32'h8C44_4C00, "is0000");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b0001, 32'h8C44_4C00, "is0001");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b0010, 32'h8C44_4C00, "is0010");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b0011, 32'h8C44_4C00, "is0011");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b0100, 32'hFFE3_1113, "is0100");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b0101, 32'hFFE3_1113, "is0101");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b0110, 32'hFFE3_1113, "is0110");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b0111, 32'hFFE3_1113, "is0111");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b1000, 32'hE000_0003, "is1000");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b1001, 32'hFFFF_F113, "is1001");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b1010, 32'h0000_0003, "is1010");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b1011, 32'h0000_0013, "is1011");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b1100, 32'hE000_0003, "is1100");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b1101, 32'hFFFF_F113, "is1101");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b1110, 32'hE000_0003, "is1110");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b1111, 32'hFFFF_F113, "is1111");

      // Positive simm13: Imm[12] = 0, upper Imm bits set but ignored.
      drive(1'b0, 32'hE000_0003, IMM_B, 4'b1001, 32'h0000_0113, "simm13p_1001");
      drive(1'b0, 32'hE000_0003, IMM_B, 4'b1101, 32'h0000_0113, "simm13p_1101");
      drive(1'b0, 32'hE000_0003, IMM_B, 4'b1111, 32'h0000_0113, "simm13p_1111");

      // Field boundaries: wide shift counts, positive disp22, full SETHI.
      drive(1'b0, 32'h1234_56FF, 22'h000000, 4'b1010, 32'h0000_001F, "rshift_max");
      drive(1'b0, 32'h0000_0000, 22'h3FFFFF, 4'b1011, 32'h0000_001F, "ishift_max");
      drive(1'b0, 32'hFFFF_FFFF, 22'h1FFFFF, 4'b0110, 32'h001F_FFFF, "disp22_pos");
      drive(1'b0, 32'h0000_0000, 22'h3FFFFF, 4'b0011, 32'hFFFF_FC00, "sethi_ones");
      drive(1'b0, 32'h5A5A_A5A5, 22'h3FFFFF, 4'b1110, 32'h5A5A_A5A5, "reg_1110");
      drive(1'b0, 32'h5A5A_A5A5, 22'h3FEFFF, 4'b1101, 32'h0000_0FFF, "simm13_hi_ign");

      // Mid-sweep single-cycle reset pulse.
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b1000, 32'hE000_0003, "pre_rst");
      drive(1'b1, 32'hE000_0003, IMM_A, 4'b1001, 32'h0000_0000, "mid_rst");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b1010, 32'h0000_0003, "post_rst0");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b1011, 32'h0000_0013, "post_rst1");
      drive(1'b0, 32'hE000_0003, IMM_A, 4'b0000, 32'h8C44_4C00, "post_rst2");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
